// File: rtl/lb_master_seq.sv
// Local-bus initiator: issues queued read/write commands as one-cycle strobes and
// returns read data through a response FIFO. Optional LB_MASTER_STATS_EN adds issue counters.
module lb_master_seq #(
    parameter int READ_PIPE = 2,
    parameter int RSP_AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [23:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        flush,
    output logic        busy,
    output logic [23:0] addr,
    output logic        control_strobe,
    output logic        control_rd,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] rsp_addr,
    output logic [31:0] rsp_data,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt
);
    // state | meaning
    // RUN   | accepting commands subject to response credit
    // FLUSH | not accepting; waiting for in-flight reads to land in the FIFO
    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam int DEPTH = 1 << RSP_AW;
    localparam int OW    = RSP_AW + 4;

    state_t             state;
    logic               pipe_v [READ_PIPE];
    logic [23:0]        pipe_a [READ_PIPE];
    logic [23:0]        mem_a  [DEPTH];
    logic [31:0]        mem_d  [DEPTH];
    logic [RSP_AW-1:0]  wr_ptr, rd_ptr;
    logic [RSP_AW:0]    fifo_cnt;
    logic [OW-1:0]      pipe_cnt, outstanding;
    logic               pipe_any, accept, push, pop;

    always_comb begin
        pipe_cnt = '0;
        pipe_any = 1'b0;
        for (int i = 0; i < READ_PIPE; i++) begin
            pipe_cnt = pipe_cnt + OW'(pipe_v[i]);
            pipe_any = pipe_any | pipe_v[i];
        end
    end

    // Credit counts every read that will eventually occupy a FIFO slot.
    assign outstanding = pipe_cnt + OW'(control_strobe & control_rd) + OW'(fifo_cnt);
    assign cmd_ready   = (state == RUN) && (outstanding < OW'(DEPTH));
    assign accept      = cmd_valid & cmd_ready;
    assign push        = pipe_v[READ_PIPE-1];
    assign pop         = rsp_valid & rsp_ready;
    assign busy        = pipe_any | control_strobe | (state == FLUSH);
    assign rsp_valid   = (fifo_cnt != '0);
    assign rsp_addr    = mem_a[rd_ptr];
    assign rsp_data    = mem_d[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            control_strobe <= 1'b0;
            control_rd     <= 1'b0;
            addr           <= '0;
            data_out       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            for (int i = 0; i < READ_PIPE; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            control_strobe <= accept;
            if (accept) begin
                addr       <= cmd_addr;
                control_rd <= cmd_rd;
                data_out   <= cmd_data;
            end
            pipe_v[0] <= control_strobe & control_rd;
            pipe_a[0] <= addr;
            for (int i = 1; i < READ_PIPE; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            if (push) wr_ptr <= wr_ptr + RSP_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + RSP_AW'(1);
            fifo_cnt <= fifo_cnt + (RSP_AW+1)'(push) - (RSP_AW+1)'(pop);
            case (state)
                RUN:     if (flush) state <= FLUSH;
                FLUSH:   if (!pipe_any && !control_strobe) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= pipe_a[READ_PIPE-1];
            mem_d[wr_ptr] <= data_in;
        end
    end

`ifdef LB_MASTER_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (control_strobe) begin
            if (control_rd) rd_cnt <= rd_cnt + 16'd1;
            else            wr_cnt <= wr_cnt + 16'd1;
        end
    end

    assign stat_rd_cnt = rd_cnt;
    assign stat_wr_cnt = wr_cnt;
`else
    assign stat_rd_cnt = '0;
    assign stat_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_lb_master_seq.sv
// Randomized scoreboard bench for lb_master_seq with a latency-2 slave model.
module tb_lb_master_seq;
    localparam int RP = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0, flush = 1'b0, busy;
    logic [23:0] cmd_addr = '0, addr, rsp_addr;
    logic [31:0] cmd_data = '0, data_out, data_in = '0, rsp_data;
    logic        control_strobe, control_rd, rsp_valid, rsp_ready = 1'b0;
    logic [15:0] stat_rd_cnt, stat_wr_cnt;

    lb_master_seq #(.READ_PIPE(RP), .RSP_AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flush(flush),
        .busy(busy), .addr(addr), .control_strobe(control_strobe), .control_rd(control_rd),
        .data_out(data_out), .data_in(data_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [23:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        bus_q[$];
    txn_t        rsp_q[$];
    int          rd_acc_q[$];
    logic [31:0] rmem[logic [23:0]];
    logic [31:0] smem[logic [23:0]];
    int          n_chk = 0, n_fail = 0, cyc = 0;
    int          rsp_mode = 0;
    bit          flush_on = 0;
    int          flush_f = 0, last_any = -100, last_rd = -100;
    logic [15:0] rd_tot = 0, wr_tot = 0, rd_prev = 0, wr_prev = 0;

    function automatic logic [31:0] dflt(logic [23:0] a);
        return {a[7:0], 8'ha5, a[23:8]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Slave: data for a read strobed in cycle c is presented during cycle c+RP.
    logic [31:0] d0 = '0, d1 = '0;
    always @(negedge clk) begin
        data_in = d1;
        d1 = d0;
        if (control_strobe && control_rd)
            d0 = smem.exists(addr) ? smem[addr] : dflt(addr);
        else
            d0 = $urandom;
        if (control_strobe && !control_rd)
            smem[addr] = data_out;
    end

    always @(posedge clk) begin
        #1;
        if (rsp_mode == 0)      rsp_ready = 1'b0;
        else if (rsp_mode == 1) rsp_ready = 1'b1;
        else                    rsp_ready = ($urandom % 3) != 0;
    end

    // Monitor: command-level reference model, checked every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus_q.delete(); rsp_q.delete(); rd_acc_q.delete();
            flush_on = 0; last_any = -100; last_rd = -100;
            rd_tot = 0; wr_tot = 0; rd_prev = 0; wr_prev = 0;
            chk("rst_strobe", control_strobe, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_stat_rd", stat_rd_cnt, 0);
            chk("rst_stat_wr", stat_wr_cnt, 0);
        end else begin
            bit   st_flush, exp_busy, exp_rv;
            int   ex;
            txn_t t;
            st_flush = 0;
            if (flush_on) begin
                ex = flush_f + 1;
                if (last_any + 2 > ex) ex = last_any + 2;
                if (last_rd + RP + 2 > ex) ex = last_rd + RP + 2;
                if (cyc <= ex) st_flush = 1;
                else flush_on = 0;
            end
            exp_busy = st_flush || (last_any == cyc - 1);
            foreach (rd_acc_q[i])
                if (rd_acc_q[i] >= cyc - RP - 1 && rd_acc_q[i] <= cyc - 2) exp_busy = 1;
            chk("busy", busy, exp_busy);
            chk("cmd_ready", cmd_ready, !st_flush && rsp_q.size() < 8);
            exp_rv = rsp_q.size() > 0 && (rsp_q[0].cyc + RP + 2 <= cyc);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (rsp_valid && rsp_ready && rsp_q.size() > 0) begin
                t = rsp_q.pop_front();
                chk("rsp_addr", rsp_addr, t.a);
                chk("rsp_data", rsp_data, t.d);
            end
            if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
                t = bus_q.pop_front();
                chk("strobe", control_strobe, 1);
                if (control_strobe) begin
                    chk("bus_addr", addr, t.a);
                    chk("bus_rd", control_rd, t.rd);
                    if (!t.rd) chk("bus_wdata", data_out, t.d);
                end
            end else if (control_strobe) begin
                chk("strobe_spurious", control_strobe, 0);
            end
`ifdef LB_MASTER_STATS_EN
            chk("stat_rd", stat_rd_cnt, rd_prev);
            chk("stat_wr", stat_wr_cnt, wr_prev);
`else
            chk("stat_rd_off", stat_rd_cnt, 0);
            chk("stat_wr_off", stat_wr_cnt, 0);
`endif
            rd_prev = rd_tot;
            wr_prev = wr_tot;
            if (cmd_valid && cmd_ready) begin
                t.cyc = cyc + 1; t.rd = cmd_rd; t.a = cmd_addr; t.d = cmd_data;
                bus_q.push_back(t);
                last_any = cyc;
                if (cmd_rd) begin
                    t.cyc = cyc;
                    t.d = rmem.exists(cmd_addr) ? rmem[cmd_addr] : dflt(cmd_addr);
                    rsp_q.push_back(t);
                    rd_acc_q.push_back(cyc);
                    last_rd = cyc;
                    rd_tot = rd_tot + 16'd1;
                end else begin
                    rmem[cmd_addr] = cmd_data;
                    wr_tot = wr_tot + 16'd1;
                end
            end
            while (rd_acc_q.size() > 0 && rd_acc_q[0] < cyc - RP - 3) void'(rd_acc_q.pop_front());
            if (flush && !st_flush) begin
                flush_on = 1;
                flush_f = cyc;
            end
        end
        cyc++;
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(logic rd, logic [23:0] a, logic [31:0] d);
        bit acc = 0;
        cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_data = d;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL issue_timeout: command at %h not accepted within 300 cycles", a);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    function automatic logic [23:0] raddr();
        return 24'h05_0000 | 24'($urandom % 16);
    endfunction

    initial begin
        bit seen;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Write then read back through the latency-2 slave.
        rsp_mode = 1;
        issue(1'b0, 24'h05_0001, 32'h3);
        issue(1'b1, 24'h05_0001, 32'h0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("t1_rsp_seen", seen, 1);
        chk("t1_rsp_data", rsp_data, 32'h3);
        idle(6);

        // Eight reads with the consumer stalled fill the FIFO and exhaust credit.
        rsp_mode = 0;
        for (int i = 0; i < 8; i++) issue(1'b1, 24'h05_0010 + 24'(i), 32'h0);
        idle(6);
        chk("t2_full_ready", cmd_ready, 0);
        chk("t2_full_valid", rsp_valid, 1);
        rsp_mode = 1;
        idle(12);

        // Read stream with the consumer always ready.
        for (int i = 0; i < 20; i++) issue(1'b1, raddr(), 32'h0);
        idle(10);

        // Flush with three reads in flight.
        rsp_mode = 0;
        issue(1'b1, 24'h05_0003, 32'h0);
        issue(1'b1, 24'h05_0004, 32'h0);
        flush = 1'b1;
        issue(1'b1, 24'h05_0005, 32'h0);
        flush = 1'b0;
        idle(8);
        chk("t4_busy_done", busy, 0);
        chk("t4_ready_back", cmd_ready, 1);
        rsp_mode = 1;
        idle(8);

        // Reset with two reads in flight, then a clean read.
        issue(1'b1, 24'h05_0006, 32'h0);
        issue(1'b1, 24'h05_0007, 32'h0);
        reset_pulse();
        @(negedge clk);
        chk("t5_rsp_empty", rsp_valid, 0);
        @(posedge clk); #1;
        issue(1'b0, 24'h05_0007, 32'hcafe_0007);
        issue(1'b1, 24'h05_0007, 32'h0);
        idle(8);

        // Randomized traffic with random consumer and occasional flush pulses.
        rsp_mode = 2;
        for (int i = 0; i < 600; i++) begin
            case ($urandom % 8)
                0:       idle(1);
                1:       begin flush = 1'b1; idle(1); flush = 1'b0; end
                2, 3, 4: issue(1'b1, raddr(), 32'h0);
                default: issue(1'b0, raddr(), $urandom);
            endcase
        end
        rsp_mode = 1;
        idle(20);

        // Statistics: five writes and three reads after reset.
        reset_pulse();
        for (int i = 0; i < 5; i++) issue(1'b0, raddr(), $urandom);
        for (int i = 0; i < 3; i++) issue(1'b1, raddr(), 32'h0);
        idle(12);
`ifdef LB_MASTER_STATS_EN
        chk("t6_stat_wr", stat_wr_cnt, 5);
        chk("t6_stat_rd", stat_rd_cnt, 3);
`else
        chk("t6_stat_wr_off", stat_wr_cnt, 0);
        chk("t6_stat_rd_off", stat_rd_cnt, 0);
`endif
        chk("sb_rsp_drained", rsp_q.size(), 0);
        chk("sb_bus_drained", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
